en_pulse_gen: RTL
=================

EN_PULSE_GEN -- requirements
Module: en_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable samples required to accept a press or a release (legal range 1..65535).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 16, meaning HELD cycles between auto-repeat pulses (legal range 2..65535; ignored unless AUTOREPEAT_EN is defined).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port btn_in, input, 1 bit: raw, bouncy, asynchronous button level, 1 = pressed.
REQ-006 SHALL have port en, output, 1 bit: registered single-cycle step pulse for the downstream 4-state counter FSM.
REQ-007 SHALL have port btn_level, output, 1 bit: debounced button level, registered.
REQ-008 SHALL have port press_cnt, output, 8 bits: count of en pulses issued.

Function
REQ-009 SHALL pass btn_in through a 2-flop synchronizer; btn_s is the second flop's output, and no other logic SHALL sample btn_in.
REQ-010 SHALL implement a 4-state FSM: IDLE, PRESS_DB, HELD, RELEASE_DB, with a shared 16-bit debounce counter cnt.
REQ-011 IDLE: if btn_s=1 -> PRESS_DB with cnt=0; else stay.
REQ-012 PRESS_DB: if btn_s=0 -> IDLE (glitch rejected, no en); else if cnt=DEBOUNCE_CYCLES-1 -> HELD; else cnt+1.
REQ-013 HELD: if btn_s=0 -> RELEASE_DB with cnt=0; else stay.
REQ-014 RELEASE_DB: if btn_s=1 -> HELD (release bounce, no en); else if cnt=DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
REQ-015 en SHALL be 1 for exactly the first cycle after each PRESS_DB->HELD transition, and 0 otherwise (except as in REQ-025).
REQ-016 Latency: btn_in held 1 from before rising edge 0 SHALL give en=1 in the cycle following edge DEBOUNCE_CYCLES+2, i.e. 7 edges at the default.
REQ-017 A RELEASE_DB->HELD return SHALL NOT produce en.
REQ-018 btn_level SHALL be 1 while the state is HELD or RELEASE_DB, and 0 in IDLE or PRESS_DB.
REQ-019 press_cnt SHALL increment by 1 in the same cycle en=1, and wrap 255->0.
REQ-020 en SHALL never be 1 in two consecutive cycles.
REQ-021 Any input pattern SHALL leave the FSM in a legal state; unreachable encodings SHALL return to IDLE on the next edge.

Reset
REQ-022 rst_n=0 SHALL immediately clear the synchronizer flops, cnt, and the repeat counter, set state=IDLE, and set en=0, btn_level=0, press_cnt=0, without waiting for clk.
REQ-023 Reset asserted mid-press SHALL abort the press; a button still held after rst_n rises SHALL be debounced from scratch and yield one en per REQ-016.

Configuration
REQ-024 Macro AUTOREPEAT_EN SHALL compile the auto-repeat feature in or out.
REQ-025 With AUTOREPEAT_EN defined: in HELD with btn_s=1, a repeat counter SHALL count cycles, issue en (and increment press_cnt) every REPEAT_CYCLES cycles after the initial pulse, and clear on HELD entry or exit and during RELEASE_DB.
REQ-026 Without AUTOREPEAT_EN: the repeat counter SHALL NOT exist, exactly one en SHALL occur per accepted press, and REPEAT_CYCLES has no effect.

Verification
REQ-027 Clean press: btn_in 0->1 held 20 cycles, default parameters -> en=1 for exactly one cycle 7 edges after the rise, btn_level=1, press_cnt=1.
REQ-028 Bounce: btn_in toggles 1,0,1,0 each cycle, then holds 1 -> no en during toggling, one en after the stable run, press_cnt=1.
REQ-029 Release bounce: while HELD, btn_in 0 for 2 cycles then 1, later clean release -> no extra en, btn_level returns to 0 DEBOUNCE_CYCLES+3 edges after the final fall.
REQ-030 Four clean presses feeding the downstream FSM -> 4 en pulses, press_cnt=4, downstream z=1; 256 presses -> press_cnt wraps to 0.
REQ-031 rst_n pulsed low for 1 cycle during PRESS_DB and during HELD, button still held -> outputs 0 asynchronously, then one fresh en 7 edges after rst_n rises.
REQ-032 AUTOREPEAT_EN defined, REPEAT_CYCLES=16, btn_in held 60 cycles -> en at edge 7, then every 16 cycles (3 repeats), press_cnt=4; macro undefined -> press_cnt=1.

Source files
------------

// File: rtl/en_pulse_gen.sv
// rtl/en_pulse_gen.sv - debounced button to single-cycle en pulse generator, auto-repeat under macro AUTOREPEAT_EN
module en_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       en,
    output logic       btn_level,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        btn_meta;
    logic        btn_s;
    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic        press_hit;
    logic        rep_hit;
    logic        en_next;
    logic        level_next;

    // Two-flop synchronizer; btn_s is the only view of the raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
        end
    end

    // State and shared debounce counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: a press or release is accepted only after a stable run
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    next_state = PRESS_DB;
                    cnt_next   = 16'd0;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    next_state = IDLE;
                end else if (cnt == DB_LAST) begin
                    next_state = HELD;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    next_state = RELEASE_DB;
                    cnt_next   = 16'd0;
                end
            end
            RELEASE_DB: begin
                if (btn_s) begin
                    next_state = HELD;
                end else if (cnt == DB_LAST) begin
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

`ifdef AUTOREPEAT_EN
    localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);

    logic [15:0] rep_cnt;
    logic [15:0] rep_next;

    // Repeat counter runs only while steadily held; any other state clears it
    always_comb begin
        rep_next = 16'd0;
        rep_hit  = 1'b0;
        if (state == HELD && btn_s) begin
            if (rep_cnt == REP_LAST) begin
                rep_hit = 1'b1;
            end else begin
                rep_next = rep_cnt + 16'd1;
            end
        end
    end

    // Repeat counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= 16'd0;
        end else begin
            rep_cnt <= rep_next;
        end
    end
`else
    // REPEAT_CYCLES has no effect in this build; this net only anchors the parameter
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
    assign rep_hit = 1'b0;
`endif

    // Output decode: pulse on accepted press (or repeat), level while pressed
    always_comb begin
        press_hit  = (state == PRESS_DB) && (next_state == HELD);
        en_next    = press_hit | rep_hit;
        level_next = (next_state == HELD) || (next_state == RELEASE_DB);
    end

    // Registered outputs and pulse counter (wraps naturally at 8 bits)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b0;
            btn_level <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            en        <= en_next;
            btn_level <= level_next;
            press_cnt <= press_cnt + {7'd0, en_next};
        end
    end

endmodule
